mem_stage: RTL

- Memory-access pipeline stage of the 16-bit CPU, between execute and writeback.
- Owns the EX/MEM pipeline register and drives the `ram` block's data-side request port (addr, data_i, op, en). Consumes its read data and its fetch-conflict pause.
- Sequences the extra cycle for accesses to the shared instruction/data SRAM (addr < 0x8000). Generates the pipeline stall request and the registered MEM/WB outputs.

---
 rtl/mem_stage_pkg.sv | 20 ++
 rtl/mem_stage_wb_reg.sv | 32 +++
 rtl/mem_stage.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared constants for the memory stage: RAM port encodings, FSM states and
// the address map boundaries that decide shared-SRAM versus single-cycle access.
package mem_stage_pkg;

    localparam logic RAM_ENABLE  = 1'b1;
    localparam logic RAM_DISABLE = 1'b0;
    localparam logic RAM_OP_RD   = 1'b0;
    localparam logic RAM_OP_WR   = 1'b1;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    // Below ADDR_SHARED_TOP the SRAM is shared with instruction fetch.
    localparam logic [17:0] ADDR_SHARED_TOP = 18'h08000;
    localparam logic [17:0] ADDR_COM_DATA   = 18'h0BF00;
    localparam logic [17:0] ADDR_COM_STATUS = 18'h0BF01;

endpackage

// File: rtl/mem_stage_wb_reg.sv
// MEM/WB pipeline register; a non-completing cycle loads a bubble (wb_en = 0)
// while the destination and data fields simply hold.
module mem_wb_reg #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              next_wb_en,
    input  logic [REG_W-1:0]  next_wb_reg,
    input  logic [DATA_W-1:0] next_wb_data,
    output logic              wb_en,
    output logic [REG_W-1:0]  wb_reg,
    output logic [DATA_W-1:0] wb_data
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en   <= 1'b0;
            wb_reg  <= '0;
            wb_data <= '0;
        end else if (load) begin
            wb_en   <= next_wb_en;
            wb_reg  <= next_wb_reg;
            wb_data <= next_wb_data;
        end else begin
            wb_en   <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: EX/MEM register, data-side RAM request, the extra cycle
// for fetch-shared SRAM accesses, and statistics counters.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 18,
    parameter int REG_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk_50MHz,
    input  logic              rst,
    input  logic              ex_mem_rd,
    input  logic              ex_mem_wr,
    input  logic [15:0]       ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              ex_wb_en,
    input  logic [REG_W-1:0]  ex_wb_reg,
    input  logic              flush,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_op,
    output logic              ram_en,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_pause,
    output logic              stall_req,
    output logic              wb_en,
    output logic [REG_W-1:0]  wb_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic [CNT_W-1:0]  stat_mem_cnt,
    output logic [CNT_W-1:0]  stat_stall_cnt,
    output state_t            state_dbg
);

    // Handshake: an EX instruction is accepted on every rising edge where
    // stall_req is low; while stall_req is high upstream holds EX inputs stable
    // and flush is ignored, so nothing is lost or duplicated.
    logic              rd_q;
    logic              wr_q;
    logic [15:0]       addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] result_q;
    logic              wb_en_q;
    logic [REG_W-1:0]  wb_reg_q;

    state_t state_q;
    state_t state_d;
    logic   complete;

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            result_q <= '0;
            wb_en_q  <= 1'b0;
            wb_reg_q <= '0;
        end else if (!stall_req) begin
            rd_q     <= ex_mem_rd & ~flush;
            wr_q     <= ex_mem_wr & ~flush;
            addr_q   <= ex_addr;
            wdata_q  <= ex_wdata;
            result_q <= ex_result;
            wb_en_q  <= ex_wb_en & ~flush;
            wb_reg_q <= ex_wb_reg;
        end
    end

    assign ram_en    = (rd_q | wr_q) ? RAM_ENABLE : RAM_DISABLE;
    assign ram_op    = wr_q ? RAM_OP_WR : RAM_OP_RD;
    assign ram_addr  = ADDR_W'(addr_q);
    assign ram_wdata = wdata_q;

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) state_q <= S_RUN;
        else     state_q <= state_d;
    end

    // The ram block raises ram_pause only for shared-SRAM addresses, so the
    // address map itself needs no decode here.
    always_comb begin
        state_d   = state_q;
        stall_req = 1'b0;
        complete  = 1'b1;
        case (state_q)
            S_RUN: begin
                if ((ram_en == RAM_ENABLE) && ram_pause) begin
                    stall_req = 1'b1;
                    complete  = 1'b0;
                    state_d   = S_HOLD;
                end
            end
            S_HOLD:  state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    assign state_dbg = state_q;

    mem_wb_reg #(
        .DATA_W(DATA_W),
        .REG_W (REG_W)
    ) u_mem_wb (
        .clk         (clk_50MHz),
        .rst         (rst),
        .load        (complete),
        .next_wb_en  (wb_en_q & ~wr_q),
        .next_wb_reg (wb_reg_q),
        .next_wb_data(rd_q ? ram_rdata : result_q),
        .wb_en       (wb_en),
        .wb_reg      (wb_reg),
        .wb_data     (wb_data)
    );

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            stat_mem_cnt   <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (complete && (rd_q || wr_q)) stat_mem_cnt <= stat_mem_cnt + CNT_W'(1);
            if (stall_req) stat_stall_cnt <= stat_stall_cnt + CNT_W'(1);
        end
    end

endmodule
